block_interleaver_pp: RTL and testbench

//  Parametrised ROWS x COLS block interleaver/deinterleaver, double-buffered (ping-pong) for continuous streaming.

---
 rtl/block_interleaver_pp.sv | 170 +++++++++++++++++
 tb/tb_block_interleaver_pp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_interleaver_pp.sv
// block_interleaver_pp
// ROWS x COLS block interleaver/deinterleaver with two ping-pong banks.
// One bank is filled row-major from the input stream while the other,
// already full, is read out through a column permutation. Mode 0
// interleaves and mode 1 applies the exact inverse permutation. The
// mode is captured per block on its first word.

module block_interleaver_pp #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 4,
   parameter int COLS   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_mode
);

   localparam int          N      = ROWS * COLS;
   localparam int          AW     = $clog2(N);
   localparam int unsigned ROWS_U = ROWS;
   localparam int unsigned COLS_U = COLS;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_st_e;

   bank_st_e          bank_st_r     [2];
   bank_st_e          bank_st_nxt_s [2];
   logic [1:0]        bank_mode_r;
   logic [AW-1:0]     wr_cnt_r;
   logic [AW-1:0]     rd_cnt_r;
   logic              wb_r;
   logic              rb_r;
   logic [DATA_W-1:0] mem0_r [N];
   logic [DATA_W-1:0] mem1_r [N];

   logic              wr_fire_s;
   logic              wr_last_s;
   logic              rd_load_s;
   logic              rd_last_s;
   logic [AW-1:0]     rd_addr_s;
   logic [DATA_W-1:0] rd_word_s;
   int unsigned       rd_k_s;

   // The write side stalls only when the bank it is about to fill still holds an unread block.
   assign in_ready  = (bank_st_r[wb_r] != BANK_FULL);
   assign wr_fire_s = in_valid & in_ready & ~clr_i;
   assign wr_last_s = (wr_cnt_r == AW'(N - 1));
   assign rd_last_s = (rd_cnt_r == AW'(N - 1));
   // The output register loads whenever it is empty or is being drained this cycle.
   assign rd_load_s = (bank_st_r[rb_r] == BANK_FULL) & (~out_valid | out_ready) & ~clr_i;

   // Permuted read address: interleave walks the matrix column by column, deinterleave uses the inverse walk.
   always_comb begin
      rd_k_s = 32'(rd_cnt_r);
      if (bank_mode_r[rb_r] == 1'b0) begin
         rd_addr_s = AW'((rd_k_s % ROWS_U) * COLS_U + (rd_k_s / ROWS_U));
      end else begin
         rd_addr_s = AW'((rd_k_s % COLS_U) * ROWS_U + (rd_k_s / COLS_U));
      end
      if (rb_r == 1'b1) begin
         rd_word_s = mem1_r[rd_addr_s];
      end else begin
         rd_word_s = mem0_r[rd_addr_s];
      end
   end

   // Next occupancy state for each bank; a flush empties both, and write and read never target the same bank.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_st_nxt_s[b] = bank_st_r[b];
         if (clr_i) begin
            bank_st_nxt_s[b] = BANK_EMPTY;
         end else if (wr_fire_s && (wb_r == 1'(b))) begin
            bank_st_nxt_s[b] = wr_last_s ? BANK_FULL : BANK_FILLING;
         end else if (rd_load_s && rd_last_s && (rb_r == 1'(b))) begin
            bank_st_nxt_s[b] = BANK_EMPTY;
         end else begin
            bank_st_nxt_s[b] = bank_st_r[b];
         end
      end
   end

   // Bank occupancy state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_st_r[0] <= BANK_EMPTY;
         bank_st_r[1] <= BANK_EMPTY;
      end else begin
         bank_st_r[0] <= bank_st_nxt_s[0];
         bank_st_r[1] <= bank_st_nxt_s[1];
      end
   end

   // Write counter, write-bank pointer and per-bank mode captured on the first word of a block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_r    <= '0;
         wb_r        <= 1'b0;
         bank_mode_r <= 2'b00;
      end else if (clr_i) begin
         wr_cnt_r <= '0;
         wb_r     <= 1'b0;
      end else if (wr_fire_s) begin
         if (wr_cnt_r == '0) begin
            bank_mode_r[wb_r] <= in_mode;
         end
         if (wr_last_s) begin
            wr_cnt_r <= '0;
            wb_r     <= ~wb_r;
         end else begin
            wr_cnt_r <= wr_cnt_r + AW'(1);
         end
      end
   end

   // Bank storage; contents are deliberately left uninitialised by reset and flush.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         if (wb_r == 1'b1) begin
            mem1_r[wr_cnt_r] <= in_data;
         end else begin
            mem0_r[wr_cnt_r] <= in_data;
         end
      end
   end

   // Read counter, read-bank pointer and the registered output stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt_r  <= '0;
         rb_r      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_mode  <= 1'b0;
      end else if (clr_i) begin
         rd_cnt_r  <= '0;
         rb_r      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (rd_load_s) begin
         out_data  <= rd_word_s;
         out_last  <= rd_last_s;
         out_mode  <= bank_mode_r[rb_r];
         out_valid <= 1'b1;
         if (rd_last_s) begin
            rd_cnt_r <= '0;
            rb_r     <= ~rb_r;
         end else begin
            rd_cnt_r <= rd_cnt_r + AW'(1);
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_block_interleaver_pp.sv
// Scoreboard bench for block_interleaver_pp: a 4x4 instance exercised with
// directed and random traffic, plus a 2x3 instance for the non-square case.
module tb_block_interleaver_pp;

   localparam int R = 4;
   localparam int C = 4;
   localparam int N = R * C;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       m;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clr_i, in_valid, in_ready, in_mode;
   logic       out_valid, out_ready, out_last, out_mode;
   logic [7:0] in_data, out_data;

   logic       b_in_valid, b_in_ready, b_in_mode;
   logic       b_out_valid, b_out_ready, b_out_last, b_out_mode;
   logic [7:0] b_in_data, b_out_data;

   exp_t       q[$];
   exp_t       qb[$];
   logic [7:0] blk_buf [N];
   int         n_cmp = 0;
   int         n_err = 0;
   int         acc = 0;
   bit         rand_rdy = 1'b0;

   block_interleaver_pp #(.DATA_W(8), .ROWS(R), .COLS(C)) dut (
      .clk(clk), .rst(rst), .clr_i(clr_i),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_mode(out_mode)
   );

   block_interleaver_pp #(.DATA_W(8), .ROWS(2), .COLS(3)) dut_b (
      .clk(clk), .rst(rst), .clr_i(clr_i),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .out_mode(b_out_mode)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for the 4x4 instance: every accepted output word is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_out: got data %0d, scoreboard empty", out_data);
         end else begin
            e = q.pop_front();
            chk("out_data", int'(out_data), int'(e.d));
            chk("out_last", int'(out_last), int'(e.l));
            chk("out_mode", int'(out_mode), int'(e.m));
         end
      end
   end

   // Monitor for the 2x3 instance.
   always @(negedge clk) begin
      exp_t e;
      if (b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL b_unexpected_out: got data %0d, scoreboard empty", b_out_data);
         end else begin
            e = qb.pop_front();
            chk("b_out_data", int'(b_out_data), int'(e.d));
            chk("b_out_last", int'(b_out_last), int'(e.l));
            chk("b_out_mode", int'(b_out_mode), int'(e.m));
         end
      end
   end

   // Count accepted input words of the 4x4 instance.
   always @(negedge clk) begin
      if (in_valid && in_ready) acc++;
   end

   // Random downstream back-pressure when enabled.
   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Reference model: fill a matrix and read it back in the other order.
   task automatic push_expected(input logic m);
      logic [7:0] mat [R][C];
      int idx = 0;
      int n = 0;
      exp_t e;
      if (!m) begin
         for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) mat[r][c] = blk_buf[idx++];
         for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) begin
            e.d = mat[r][c]; e.l = (n == N - 1); e.m = m; q.push_back(e); n++;
         end
      end else begin
         for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) mat[r][c] = blk_buf[idx++];
         for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
            e.d = mat[r][c]; e.l = (n == N - 1); e.m = m; q.push_back(e); n++;
         end
      end
   endtask

   task automatic put_word(input logic [7:0] d, input logic m);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_mode = m;
      @(negedge clk);
      while (!in_ready && t < 300) begin t++; @(negedge clk); end
      if (!in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic put_word_b(input logic [7:0] d, input logic m);
      int t = 0;
      b_in_valid = 1'b1; b_in_data = d; b_in_mode = m;
      @(negedge clk);
      while (!b_in_ready && t < 300) begin t++; @(negedge clk); end
      if (!b_in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL b_in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", t);
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask

   // Send blk_buf as one block; in_mode is scrambled after the first word since it must be ignored there.
   task automatic send_block(input logic m, input int gap_max);
      for (int i = 0; i < N; i++) begin
         if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #1;
         end
         put_word(blk_buf[i], (i == 0) ? m : 1'($urandom_range(0, 1)));
      end
      push_expected(m);
   endtask

   task automatic fill_seq();
      for (int i = 0; i < N; i++) blk_buf[i] = 8'(i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < N; i++) blk_buf[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic drain();
      int t = 0;
      rand_rdy = 1'b0; out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && t < 500) begin @(negedge clk); t++; end
      if (q.size() != 0 || out_valid) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: got %0d words outstanding, expected 0", q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int t;
      int bubbles;
      exp_t e;
      rst = 1'b0; clr_i = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_mode = 1'b0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = 8'd0; b_in_mode = 1'b0; b_out_ready = 1'b1;
      #12;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_mode", int'(out_mode), 0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // Plain interleave of 0..15, plus first-output latency.
      fill_seq();
      send_block(1'b0, 0);
      chk("latency_before", int'(out_valid), 0);
      @(posedge clk); #1;
      chk("latency_first", int'(out_valid), 1);
      drain();

      // Deinterleave the interleaved sequence back to 0..15.
      for (int k = 0; k < N; k++) blk_buf[k] = 8'((k % R) * C + k / R);
      send_block(1'b1, 0);
      drain();

      // 2x3 instance: 0..5 in both modes.
      begin
         int exp0 [6] = '{0, 3, 1, 4, 2, 5};
         int exp1 [6] = '{0, 2, 4, 1, 3, 5};
         for (int i = 0; i < 6; i++) begin e.d = 8'(exp0[i]); e.l = (i == 5); e.m = 1'b0; qb.push_back(e); end
         for (int i = 0; i < 6; i++) put_word_b(8'(i), 1'b0);
         for (int i = 0; i < 6; i++) begin e.d = 8'(exp1[i]); e.l = (i == 5); e.m = 1'b1; qb.push_back(e); end
         for (int i = 0; i < 6; i++) put_word_b(8'(i), 1'b1);
         t = 0;
         while ((qb.size() != 0 || b_out_valid) && t < 100) begin @(negedge clk); t++; end
         chk("b_drained", qb.size(), 0);
         @(posedge clk); #1;
      end

      // Back-to-back blocks with alternating mode must stream without bubbles.
      fork
         begin
            for (int b = 0; b < 3; b++) begin fill_rand(); send_block(1'(b % 2), 0); end
         end
      join_none
      t = 0;
      while (!out_valid && t < 100) begin @(negedge clk); t++; end
      bubbles = 0;
      repeat (3 * N - 1) begin @(negedge clk); if (!out_valid) bubbles++; end
      chk("no_bubble", bubbles, 0);
      wait fork;
      drain();

      // Stalled output: exactly two blocks are buffered, then everything emerges intact.
      out_ready = 1'b0;
      acc = 0;
      fork
         begin
            fill_seq(); send_block(1'b0, 0);
            fill_rand(); send_block(1'b1, 0);
            fill_rand(); send_block(1'b0, 0);
         end
      join_none
      repeat (60) @(negedge clk);
      chk("stall_accepts", acc, 2 * N);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait fork;
      drain();

      // Async reset mid-block discards the partial block.
      for (int i = 0; i < 7; i++) put_word(8'(100 + i), 1'b1);
      rst = 1'b0; #1;
      chk("rst_mid_out_valid", int'(out_valid), 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      fill_seq(); send_block(1'b0, 0);
      drain();

      // Flush with a full pending block and a partial block.
      out_ready = 1'b0;
      fill_rand(); send_block(1'b1, 0);
      for (int i = 0; i < 3; i++) put_word(8'(200 + i), 1'b0);
      clr_i = 1'b1;
      @(posedge clk); #1;
      clr_i = 1'b0;
      q.delete();
      chk("clr_out_valid", int'(out_valid), 0);
      chk("clr_in_ready", int'(in_ready), 1);
      out_ready = 1'b1;
      fill_seq(); send_block(1'b0, 0);
      drain();

      // Random traffic with gaps and back-pressure.
      rand_rdy = 1'b1;
      for (int b = 0; b < 6; b++) begin fill_rand(); send_block(1'($urandom_range(0, 1)), 2); end
      drain();
      chk("final_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
